// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit and its MDU stall timer.
package hazard_unit_pkg;

  typedef enum logic {
    StRun     = 1'b0,
    StMduWait = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO            = 5'd0;
  localparam int unsigned MDU_LATENCY_DEFAULT = 4;
  localparam int unsigned TIMER_W             = 5;

  // $zero never creates a dependency, so it can never match.
  function automatic logic reg_match(logic [4:0] dst, logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/mdu_timer.sv
// Loadable down-counter that times the multiply/divide stall window.
module mdu_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stalls, branch/jump flushes, multi-cycle MDU freeze
// and a saturating stall-cycle performance counter.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = MDU_LATENCY_DEFAULT,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             mdu_start,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [TIMER_W-1:0] LoadVal = TIMER_W'(MDU_LATENCY - 1);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] stall_d, stall_q;
  logic             load_use;
  logic             timer_load, timer_dec, timer_zero;

  assign load_use = ex_mem_read && (reg_match(ex_rt, id_rs) || reg_match(ex_rt, id_rt));

  always_comb begin
    state_d      = state_q;
    pc_enable    = 1'b0;
    if_id_enable = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    timer_load   = 1'b0;
    timer_dec    = 1'b0;
    if (reset) begin
      unique case (state_q)
        StRun: begin
          pc_enable    = !load_use;
          if_id_enable = !load_use;
          id_ex_bubble = load_use;
          // Flush is dropped under a load-use stall: ID is re-evaluated next cycle.
          if_id_flush  = (branch_taken || jump) && !load_use;
          if (mdu_start) begin
            state_d    = StMduWait;
            timer_load = 1'b1;
          end
        end
        StMduWait: begin
          ex_hold   = 1'b1;
          timer_dec = 1'b1;
          if (timer_zero) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_enable && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;

  mdu_timer #(
    .W (TIMER_W)
  ) u_mdu_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (LoadVal),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a scoreboard of expected outputs per cycle.
module tb_hazard_unit;

  typedef struct packed {
    logic        pc;
    logic        ifid;
    logic        flush;
    logic        bubble;
    logic        hold;
    logic [15:0] cnt;
    logic [3:0]  sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        ex_mem_read = 1'b0, branch_taken = 1'b0, jump = 1'b0, mdu_start = 1'b0;
  logic        pc_enable, if_id_enable, if_id_flush, id_ex_bubble, ex_hold;
  logic [15:0] stall_count;
  logic        s_pc, s_ifid, s_flush, s_bubble, s_hold;
  logic [3:0]  s_stall;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   exp_stall = 0;
  int   exp_sat = 0;

  always #5 clk = ~clk;

  hazard_unit u_dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .jump         (jump),
    .mdu_start    (mdu_start),
    .pc_enable    (pc_enable),
    .if_id_enable (if_id_enable),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_hold      (ex_hold),
    .stall_count  (stall_count)
  );

  hazard_unit #(
    .CNT_W (4)
  ) u_sat (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .jump         (jump),
    .mdu_start    (mdu_start),
    .pc_enable    (s_pc),
    .if_id_enable (s_ifid),
    .if_id_flush  (s_flush),
    .id_ex_bubble (s_bubble),
    .ex_hold      (s_hold),
    .stall_count  (s_stall)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, expv, $time);
  endtask

  // One cycle: drive at negedge, compare 1ns later, then advance the stall model.
  // eo = {pc_enable, if_id_enable, if_id_flush, id_ex_bubble, ex_hold}
  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic mr, input logic [4:0] ert, input logic br,
                      input logic jp, input logic md, input logic [4:0] eo);
    exp_t e;
    @(negedge clk);
    reset = rst; id_rs = rs; id_rt = rt; ex_mem_read = mr; ex_rt = ert;
    branch_taken = br; jump = jp; mdu_start = md;
    if (!rst) begin
      exp_stall = 0;
      exp_sat   = 0;
    end
    e.pc = eo[4]; e.ifid = eo[3]; e.flush = eo[2]; e.bubble = eo[1]; e.hold = eo[0];
    e.cnt = 16'(exp_stall);
    e.sat = 4'(exp_sat);
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    chk("pc_enable",    16'(pc_enable),    16'(e.pc));
    chk("if_id_enable", 16'(if_id_enable), 16'(e.ifid));
    chk("if_id_flush",  16'(if_id_flush),  16'(e.flush));
    chk("id_ex_bubble", 16'(id_ex_bubble), 16'(e.bubble));
    chk("ex_hold",      16'(ex_hold),      16'(e.hold));
    chk("stall_count",  stall_count,       e.cnt);
    chk("sat_count",    16'(s_stall),      16'(e.sat));
    if (rst && !e.pc) begin
      if (exp_stall < 65535) exp_stall++;
      if (exp_sat < 15) exp_sat++;
    end
  endtask

  initial begin
    // Reset state, then normal run
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
    // Load-use on rs: single bubble cycle
    step(1, 8, 3, 1, 8, 0, 0, 0, 5'b00010);
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
    // Load into $zero never stalls
    step(1, 0, 0, 1, 0, 0, 0, 0, 5'b11000);
    // Branch and jump flush
    step(1, 1, 2, 0, 0, 1, 0, 0, 5'b11100);
    step(1, 1, 2, 0, 0, 0, 1, 0, 5'b11100);
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
    // Branch with load-use on rt: stall wins, no flush
    step(1, 4, 9, 1, 9, 1, 0, 0, 5'b00010);
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
    // MDU freeze: exactly 4 cycles, everything else ignored
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'b11000);
    step(1, 0, 0, 0, 0, 0, 1, 0, 5'b00001);
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'b00001);
    step(1, 7, 0, 1, 7, 0, 1, 0, 5'b00001);
    step(1, 0, 0, 0, 0, 1, 1, 0, 5'b00001);
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
    step(1, 0, 0, 0, 0, 0, 1, 0, 5'b11100);
    // Reset during the second MDU_WAIT cycle aborts the wait
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'b11000);
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b00001);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
    // Saturation on the 4-bit instance with 20 stalled cycles
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    for (int i = 0; i < 20; i++) begin
      step(1, 5, 0, 1, 5, 0, 0, 0, 5'b00010);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
